// File: rtl/exec_core_mc_if.sv
// Command/response bundle between the sequencer (master) and the multi-cycle
// execution core (slave).
interface exec_core_mc_if #(
   parameter int DATA_W    = 32,
   parameter int REG_COUNT = 16,
   parameter int MEM_DEPTH = 64
);
   localparam int RW   = $clog2(REG_COUNT);
   localparam int MA_W = $clog2(MEM_DEPTH) + 1;

   logic              in_valid;
   logic              in_ready;
   logic [3:0]        opcode;
   logic [RW-1:0]     rd;
   logic [RW-1:0]     rs1;
   logic [RW-1:0]     rs2;
   logic [MA_W-1:0]   mem_addr;
   logic [DATA_W-1:0] data_in;
   logic              priv;
   logic              out_valid;
   logic [DATA_W-1:0] result;
   logic              zero;
   logic              carry;
   logic              fault;
   logic              busy;

   modport master (
      output in_valid, opcode, rd, rs1, rs2, mem_addr, data_in, priv,
      input  in_ready, out_valid, result, zero, carry, fault, busy
   );

   modport slave (
      input  in_valid, opcode, rd, rs1, rs2, mem_addr, data_in, priv,
      output in_ready, out_valid, result, zero, carry, fault, busy
   );
endinterface

// File: rtl/exec_core_mc.sv
// Multi-cycle execution core: register file, ALU and data memory sequenced
// IDLE -> EXEC -> (MEM) -> WB, one command in flight, with a privileged region.
module exec_core_mc #(
   parameter int DATA_W      = 32,
   parameter int REG_COUNT   = 16,
   parameter int MEM_DEPTH   = 64,
   parameter int SECURE_BASE = 48
) (
   input logic           clk,
   input logic           rst_n,
   exec_core_mc_if.slave bus
);
   localparam int RW   = $clog2(REG_COUNT);
   localparam int AW   = $clog2(MEM_DEPTH);
   localparam int MA_W = AW + 1;
   localparam int SW   = $clog2(DATA_W);
   localparam logic [MA_W-1:0] DEPTH_LIM  = MA_W'(MEM_DEPTH);
   localparam logic [MA_W-1:0] SECURE_LIM = MA_W'(SECURE_BASE);

   localparam logic [3:0] OP_NOP   = 4'd0,  OP_ADD  = 4'd1,  OP_SUB   = 4'd2,
                          OP_AND   = 4'd3,  OP_OR   = 4'd4,  OP_XOR   = 4'd5,
                          OP_SLL   = 4'd6,  OP_SRL  = 4'd7,  OP_SLT   = 4'd8,
                          OP_LOADI = 4'd9,  OP_LOAD = 4'd10, OP_STORE = 4'd11;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM, S_WB} state_t;

   state_t            state_q, state_d;
   logic [3:0]        op_q;
   logic [RW-1:0]     rd_q, rs1_q, rs2_q;
   logic [AW-1:0]     addr_q;
   logic [DATA_W-1:0] imm_q;
   logic              fault_q;

   logic [DATA_W-1:0] regs [REG_COUNT];
   logic [DATA_W-1:0] mem  [MEM_DEPTH];

   logic [DATA_W-1:0] op_a, op_b, alu_d, alu_q, mem_rdata, wb_data;
   logic [DATA_W:0]   sum_ext;
   logic              carry_d, carry_q;
   logic              accept, is_mem, cmd_mem, cmd_fault, wb_write;

   logic              out_valid_q, zero_q, carry_out_q, fault_out_q;
   logic [DATA_W-1:0] result_q;

   assign accept  = bus.in_valid && (state_q == S_IDLE);
   assign cmd_mem = (bus.opcode == OP_LOAD) || (bus.opcode == OP_STORE);
   // Privilege and range are judged on the command as presented, so later input changes cannot alter it.
   assign cmd_fault = (bus.opcode > OP_STORE) ||
                      (cmd_mem && ((bus.mem_addr >= DEPTH_LIM) ||
                                   ((bus.mem_addr >= SECURE_LIM) && !bus.priv)));

   assign is_mem   = (op_q == OP_LOAD) || (op_q == OP_STORE);
   assign wb_data  = (op_q == OP_LOAD) ? mem_rdata : alu_q;
   assign wb_write = !fault_q && (rd_q != '0) && (op_q != OP_STORE) && (op_q != OP_NOP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_EXEC;
         S_EXEC:  state_d = is_mem ? S_MEM : S_WB;
         S_MEM:   state_d = S_WB;
         S_WB:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q    <= OP_NOP;
         rd_q    <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         addr_q  <= '0;
         imm_q   <= '0;
         fault_q <= 1'b0;
      end else if (accept) begin
         // NOTE: non-blocking so every latch register samples the same pre-edge inputs.
         op_q    <= bus.opcode;
         rd_q    <= bus.rd;
         rs1_q   <= bus.rs1;
         rs2_q   <= bus.rs2;
         addr_q  <= bus.mem_addr[AW-1:0];
         imm_q   <= bus.data_in;
         fault_q <= cmd_fault;
      end
   end

   assign op_a = regs[rs1_q];
   assign op_b = regs[rs2_q];

   always_comb begin
      alu_d   = '0;
      carry_d = 1'b0;
      sum_ext = '0;
      case (op_q)
         OP_ADD: begin
            sum_ext = {1'b0, op_a} + {1'b0, op_b};
            alu_d   = sum_ext[DATA_W-1:0];
            carry_d = sum_ext[DATA_W];
         end
         OP_SUB: begin
            // The extra bit of the widened difference is the unsigned borrow.
            sum_ext = {1'b0, op_a} - {1'b0, op_b};
            alu_d   = sum_ext[DATA_W-1:0];
            carry_d = sum_ext[DATA_W];
         end
         OP_AND:   alu_d = op_a & op_b;
         OP_OR:    alu_d = op_a | op_b;
         OP_XOR:   alu_d = op_a ^ op_b;
         OP_SLL:   alu_d = op_a << op_b[SW-1:0];
         OP_SRL:   alu_d = op_a >> op_b[SW-1:0];
         OP_SLT:   alu_d = DATA_W'($signed(op_a) < $signed(op_b));
         OP_LOADI: alu_d = imm_q;
         OP_STORE: alu_d = op_a;
         default:  alu_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      end else if ((state_q == S_WB) && wb_write) begin
         regs[rd_q] <= wb_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: memory must clear on reset, so it is built from flops rather than a RAM macro.
         for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
         mem_rdata <= '0;
      end else if ((state_q == S_MEM) && !fault_q) begin
         if (op_q == OP_STORE) mem[addr_q] <= alu_q;
         if (op_q == OP_LOAD)  mem_rdata   <= mem[addr_q];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_q       <= '0;
         carry_q     <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         carry_out_q <= 1'b0;
         fault_out_q <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         if (state_q == S_EXEC) begin
            alu_q   <= alu_d;
            carry_q <= carry_d;
         end
         if (state_q == S_WB) begin
            out_valid_q <= 1'b1;
            result_q    <= fault_q ? '0 : wb_data;
            zero_q      <= !fault_q && (wb_data == '0);
            carry_out_q <= !fault_q && carry_q;
            fault_out_q <= fault_q;
         end
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.zero      = zero_q;
   assign bus.carry     = carry_out_q;
   assign bus.fault     = fault_out_q;
endmodule

// File: tb/tb_exec_core_mc.sv
// Directed vector bench for exec_core_mc: a command table plus hand-written
// reset, handshake and mid-command reset sequences.
module tb_exec_core_mc;
   localparam logic [3:0] OP_NOP   = 4'd0,  OP_ADD  = 4'd1,  OP_SUB   = 4'd2,
                          OP_AND   = 4'd3,  OP_OR   = 4'd4,  OP_XOR   = 4'd5,
                          OP_SLL   = 4'd6,  OP_SRL  = 4'd7,  OP_SLT   = 4'd8,
                          OP_LOADI = 4'd9,  OP_LOAD = 4'd10, OP_STORE = 4'd11;

   typedef struct {
      logic [3:0]  op;
      logic [3:0]  rd;
      logic [3:0]  rs1;
      logic [3:0]  rs2;
      logic [6:0]  addr;
      logic [31:0] imm;
      logic        priv;
      int          lat;
      logic [31:0] res;
      logic        z;
      logic        c;
      logic        f;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   exec_core_mc_if #(.DATA_W(32), .REG_COUNT(16), .MEM_DEPTH(64)) bus ();

   exec_core_mc #(.DATA_W(32), .REG_COUNT(16), .MEM_DEPTH(64), .SECURE_BASE(48)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] op, input int rd, input int rs1, input int rs2,
                               input int addr, input logic [31:0] imm, input int priv,
                               input int lat, input logic [31:0] res,
                               input int z, input int c, input int f);
      vec_t v;
      v.op = op;  v.rd = 4'(rd);  v.rs1 = 4'(rs1);  v.rs2 = 4'(rs2);
      v.addr = 7'(addr);  v.imm = imm;  v.priv = 1'(priv);
      v.lat = lat;  v.res = res;  v.z = 1'(z);  v.c = 1'(c);  v.f = 1'(f);
      return v;
   endfunction

   task automatic drive(input vec_t c);
      bus.opcode   = c.op;
      bus.rd       = c.rd;
      bus.rs1      = c.rs1;
      bus.rs2      = c.rs2;
      bus.mem_addr = c.addr;
      bus.data_in  = c.imm;
      bus.priv     = c.priv;
   endtask

   // Issue one command from a negedge and wait for its completion pulse.
   task automatic run_cmd(input vec_t c, output int lat, output logic [31:0] res,
                          output logic z, output logic cy, output logic f);
      int n;
      drive(c);
      bus.in_valid = 1'b1;
      n = 0;
      while (!bus.in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.opcode   = 4'hC;
      bus.rd       = ~c.rd;
      bus.rs1      = ~c.rs1;
      bus.rs2      = ~c.rs2;
      bus.mem_addr = ~c.addr;
      bus.data_in  = ~c.imm;
      bus.priv     = ~c.priv;
      lat = 99;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) begin
            lat = k;
            break;
         end
      end
      res = bus.result;
      z   = bus.zero;
      cy  = bus.carry;
      f   = bus.fault;
   endtask

   task automatic run_checked(input string tag, input vec_t c);
      int          lat;
      logic [31:0] res;
      logic        z, cy, f;
      @(negedge clk);
      run_cmd(c, lat, res, z, cy, f);
      check({tag, " latency"}, 32'(lat), 32'(c.lat));
      check({tag, " result"},  res, c.res);
      check({tag, " zero"},    32'(z),  32'(c.z));
      check({tag, " carry"},   32'(cy), 32'(c.c));
      check({tag, " fault"},   32'(f),  32'(c.f));
      @(posedge clk);
      #1;
      check({tag, " pulse width"}, 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      int          outs, accepts, stall_cycles, idx, ov_seen;
      logic [31:0] got [4];
      logic        rdy;
      vec_t        hs [3];

      bus.in_valid = 1'b0;
      drive(mk(OP_NOP, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0));

      // Reset state
      #2;
      check("rst in_ready",  32'(bus.in_ready),  32'd1);
      check("rst busy",      32'(bus.busy),      32'd0);
      check("rst out_valid", 32'(bus.out_valid), 32'd0);
      check("rst result",    bus.result,         32'd0);
      check("rst flags",     {29'd0, bus.zero, bus.carry, bus.fault}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      //                op        rd rs1 rs2 addr imm            pr lat res           z  c  f
      vecs.push_back(mk(OP_LOADI,  1, 0,  0,  0, 32'hFFFF_FFFF, 0, 2, 32'hFFFF_FFFF, 0, 0, 0));
      vecs.push_back(mk(OP_LOADI,  2, 0,  0,  0, 32'h0000_0001, 0, 2, 32'h0000_0001, 0, 0, 0));
      vecs.push_back(mk(OP_ADD,    3, 1,  2,  0, 32'h0,         0, 2, 32'h0000_0000, 1, 1, 0));
      vecs.push_back(mk(OP_SUB,    4, 2,  1,  0, 32'h0,         0, 2, 32'h0000_0002, 0, 1, 0));
      vecs.push_back(mk(OP_SUB,    7, 1,  2,  0, 32'h0,         0, 2, 32'hFFFF_FFFE, 0, 0, 0));
      vecs.push_back(mk(OP_ADD,    3, 2,  2,  0, 32'h0,         0, 2, 32'h0000_0002, 0, 0, 0));
      vecs.push_back(mk(OP_AND,    8, 1,  2,  0, 32'h0,         0, 2, 32'h0000_0001, 0, 0, 0));
      vecs.push_back(mk(OP_OR,     8, 3,  2,  0, 32'h0,         0, 2, 32'h0000_0003, 0, 0, 0));
      vecs.push_back(mk(OP_XOR,    9, 1,  2,  0, 32'h0,         0, 2, 32'hFFFF_FFFE, 0, 0, 0));
      vecs.push_back(mk(OP_SLT,   10, 1,  2,  0, 32'h0,         0, 2, 32'h0000_0001, 0, 0, 0));
      vecs.push_back(mk(OP_SLT,   10, 2,  1,  0, 32'h0,         0, 2, 32'h0000_0000, 1, 0, 0));
      vecs.push_back(mk(OP_LOADI, 11, 0,  0,  0, 32'd33,        0, 2, 32'd33,        0, 0, 0));
      vecs.push_back(mk(OP_SLL,   12, 2, 11,  0, 32'h0,         0, 2, 32'h0000_0002, 0, 0, 0));
      vecs.push_back(mk(OP_SRL,   12, 1, 11,  0, 32'h0,         0, 2, 32'h7FFF_FFFF, 0, 0, 0));
      vecs.push_back(mk(OP_STORE,  0, 2,  0,  5, 32'h0,         0, 3, 32'h0000_0001, 0, 0, 0));
      vecs.push_back(mk(OP_LOAD,   5, 0,  0,  5, 32'h0,         0, 3, 32'h0000_0001, 0, 0, 0));
      vecs.push_back(mk(OP_STORE,  0, 5,  0,  6, 32'h0,         0, 3, 32'h0000_0001, 0, 0, 0));
      vecs.push_back(mk(OP_LOADI, 13, 0,  0,  0, 32'hA5A5_A5A5, 0, 2, 32'hA5A5_A5A5, 0, 0, 0));
      vecs.push_back(mk(OP_STORE,  0, 13, 0, 50, 32'h0,         0, 3, 32'h0000_0000, 0, 0, 1));
      vecs.push_back(mk(OP_LOAD,  14, 0,  0, 50, 32'h0,         1, 3, 32'h0000_0000, 1, 0, 0));
      vecs.push_back(mk(OP_STORE,  0, 13, 0, 50, 32'h0,         1, 3, 32'hA5A5_A5A5, 0, 0, 0));
      vecs.push_back(mk(OP_LOAD,  15, 0,  0, 50, 32'h0,         0, 3, 32'h0000_0000, 0, 0, 1));
      vecs.push_back(mk(OP_STORE,  0, 15, 0,  7, 32'h0,         0, 3, 32'h0000_0000, 1, 0, 0));
      vecs.push_back(mk(OP_LOAD,  14, 0,  0, 50, 32'h0,         1, 3, 32'hA5A5_A5A5, 0, 0, 0));
      vecs.push_back(mk(OP_LOAD,   9, 0,  0, 47, 32'h0,         0, 3, 32'h0000_0000, 1, 0, 0));
      vecs.push_back(mk(OP_STORE,  0, 13, 0, 63, 32'h0,         1, 3, 32'hA5A5_A5A5, 0, 0, 0));
      vecs.push_back(mk(OP_LOAD,   9, 0,  0, 63, 32'h0,         1, 3, 32'hA5A5_A5A5, 0, 0, 0));
      vecs.push_back(mk(OP_LOAD,   9, 0,  0, 64, 32'h0,         1, 3, 32'h0000_0000, 0, 0, 1));
      vecs.push_back(mk(OP_STORE,  0, 2,  0, 127, 32'h0,        1, 3, 32'h0000_0000, 0, 0, 1));
      vecs.push_back(mk(4'd13,     2, 1,  2,  0, 32'h0,         1, 2, 32'h0000_0000, 0, 0, 1));
      vecs.push_back(mk(4'd15,     2, 1,  2,  0, 32'h0,         1, 2, 32'h0000_0000, 0, 0, 1));
      vecs.push_back(mk(OP_STORE,  0, 2,  0,  8, 32'h0,         0, 3, 32'h0000_0001, 0, 0, 0));
      vecs.push_back(mk(OP_LOADI,  0, 0,  0,  0, 32'd7,         0, 2, 32'd7,         0, 0, 0));
      vecs.push_back(mk(OP_ADD,    6, 0,  0,  0, 32'h0,         0, 2, 32'h0000_0000, 1, 0, 0));
      vecs.push_back(mk(OP_ADD,    6, 0,  2,  0, 32'h0,         0, 2, 32'h0000_0001, 0, 0, 0));
      vecs.push_back(mk(OP_NOP,    0, 0,  0,  0, 32'h0,         0, 2, 32'h0000_0000, 1, 0, 0));
      vecs.push_back(mk(OP_STORE,  0, 9,  0,  9, 32'h0,         0, 3, 32'hA5A5_A5A5, 0, 0, 0));

      foreach (vecs[i]) run_checked($sformatf("v%0d", i), vecs[i]);

      // Back-to-back commands with in_valid held high
      hs[0] = mk(OP_LOADI, 1, 0, 0, 0, 32'd10, 0, 2, 32'd10, 0, 0, 0);
      hs[1] = mk(OP_LOADI, 2, 0, 0, 0, 32'd20, 0, 2, 32'd20, 0, 0, 0);
      hs[2] = mk(OP_ADD,   3, 1, 2, 0, 32'h0,  0, 2, 32'd30, 0, 0, 0);
      outs = 0; accepts = 0; stall_cycles = 0; idx = 0;
      for (int cyc = 0; cyc < 16; cyc++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            if (outs < 4) got[outs] = bus.result;
            outs++;
         end
         if (!bus.in_ready) stall_cycles++;
         if (bus.busy === bus.in_ready) check($sformatf("hs busy c%0d", cyc), 32'(bus.busy), 32'(!bus.in_ready));
         if (idx < 3) begin
            drive(hs[idx]);
            bus.in_valid = 1'b1;
         end else begin
            bus.in_valid = 1'b0;
         end
         rdy = bus.in_ready;
         @(posedge clk);
         if (rdy && bus.in_valid) begin
            idx++;
            accepts++;
         end
      end
      bus.in_valid = 1'b0;
      check("hs accepts",     32'(accepts),      32'd3);
      check("hs out count",   32'(outs),         32'd3);
      check("hs stall",       32'(stall_cycles), 32'd6);
      check("hs out0",        got[0],            32'd10);
      check("hs out1",        got[1],            32'd20);
      check("hs out2",        got[2],            32'd30);

      // Reset during EXEC of ADD R1 abandons the command
      run_checked("pre-rst", mk(OP_LOADI, 1, 0, 0, 0, 32'h0000_1234, 0, 2, 32'h0000_1234, 0, 0, 0));
      @(negedge clk);
      drive(mk(OP_ADD, 1, 1, 1, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0));
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("mid busy before rst", 32'(bus.busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid rst in_ready",  32'(bus.in_ready),  32'd1);
      check("mid rst busy",      32'(bus.busy),      32'd0);
      check("mid rst out_valid", 32'(bus.out_valid), 32'd0);
      check("mid rst result",    bus.result,         32'd0);
      check("mid rst flags",     {29'd0, bus.zero, bus.carry, bus.fault}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ov_seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.out_valid) ov_seen++;
      end
      check("mid rst no out_valid", 32'(ov_seen), 32'd0);
      run_checked("post-rst R1", mk(OP_STORE, 0, 1, 0, 0, 32'h0, 0, 3, 32'h0, 1, 0, 0));
      run_checked("post-rst mem5", mk(OP_LOAD, 3, 0, 0, 5, 32'h0, 0, 3, 32'h0, 1, 0, 0));
      run_checked("post-rst mem50", mk(OP_LOAD, 3, 0, 0, 50, 32'h0, 1, 3, 32'h0, 1, 0, 0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/exec_core_mc.md
Name: exec_core_mc

Overview:
Parametrised multi-cycle execution core and the successor to the single-cycle top_main datapath.
- Integrates register file, ALU and data memory behind a valid/ready command handshake with a state machine.
- Adds carry and fault flags, plus a privileged secure memory region for the secured RISC-V platform.
- Sits between the decode/sequencer logic and the bus; one command is in flight at a time.

Parameters:
DATA_W, 32, datapath and register width
REG_COUNT, 16, number of architectural registers (power of 2); R0 hardwired to zero
MEM_DEPTH, 64, data memory words (power of 2)
SECURE_BASE, 48, first memory word address of the privileged region

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  command valid
in_ready  output  1  core can accept a command (high only in IDLE)
opcode  input  4  operation, encoding below
rd  input  $clog2(REG_COUNT)  destination register
rs1  input  $clog2(REG_COUNT)  source register 1
rs2  input  $clog2(REG_COUNT)  source register 2
mem_addr  input  $clog2(MEM_DEPTH)+1  memory word address; extra MSB allows out-of-range detection
data_in  input  DATA_W  immediate for LOADI
priv  input  1  privileged command
out_valid  output  1  one-cycle completion pulse
result  output  DATA_W  ALU result, loaded data, or stored data
zero  output  1  result == 0
carry  output  1  ADD carry-out or SUB borrow
fault  output  1  command rejected
busy  output  1  not in IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=1; busy=0; out_valid=0.
  - result=0, zero=0, carry=0, fault=0.
  - All registers and all memory words cleared to 0.
  - Reset during any state abandons the command: no register or memory write, no out_valid.
- Opcodes:
  - 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL, 8 SLT (signed, result 0/1), 9 LOADI (rd<=data_in), 10 LOAD (rd<=mem[mem_addr]), 11 STORE (mem[mem_addr]<=R[rs1]).
  - 12-15 illegal.
- Handshake and latching:
  - Accept when in_valid && in_ready at a rising edge.
  - All inputs, including priv, are latched at acceptance; later input changes are ignored.
  - No backpressure on the output side.
- State machine: IDLE -> EXEC -> (MEM for LOAD/STORE) -> WB -> IDLE.
  - EXEC reads R[rs1], R[rs2] and computes the ALU result and flags.
  - MEM performs a synchronous memory read or write.
  - WB writes rd (skipped for STORE, NOP, faults, and rd=0), asserts out_valid for one cycle, then returns to IDLE.
- Latency from accept edge to out_valid high:
  - ALU, NOP, LOADI, illegal opcode: 2 cycles.
  - LOAD, STORE: 3 cycles, including faulted memory ops.
  - Next command accepted at the earliest on the cycle after out_valid.
- Width rules:
  - ADD/SUB are computed at DATA_W+1 bits. carry = bit DATA_W for ADD; carry = (rs1 < rs2 unsigned) for SUB. carry=0 for all other ops.
  - Shift amount = R[rs2][$clog2(DATA_W)-1:0]. SRL is logical.
  - Overflow wraps modulo 2^DATA_W.
- R0: always reads as 0; writes to it are discarded. Flags are still produced for rd=0.
- Faults:
  - Triggers: illegal opcode; mem_addr >= MEM_DEPTH; or LOAD/STORE with mem_addr >= SECURE_BASE and priv=0.
  - On fault: fault=1, result=0, zero=0, carry=0, no register or memory update.
- Flag timing: result, zero, carry and fault update only in WB and hold until the next WB.
- A STORE followed by a LOAD to the same address returns the new data.

Test Plan:
- Reset mid-command: assert rst_n=0 during EXEC of ADD R1 -> no out_valid, R1=0, all outputs 0, in_ready=1.
- ALU path:
  - LOADI R1=0xFFFFFFFF, LOADI R2=1, ADD R3,R1,R2 -> result=0, zero=1, carry=1, out_valid 2 cycles after accept.
  - SUB R4,R2,R1 -> result=2, carry=1.
- Memory path: STORE R2 to addr 5, then LOAD R5 from addr 5 -> LOAD result=1, out_valid 3 cycles after accept, R5=1.
- Secure region:
  - STORE to addr 50 with priv=0 -> fault=1, mem[50] unchanged.
  - Same command with priv=1 succeeds; a subsequent LOAD from 50 with priv=0 -> fault=1, result=0.
- Boundaries:
  - mem_addr=64 -> fault.
  - opcode=13 -> fault after 2 cycles.
  - LOADI R0=7, then ADD R6,R0,R0 -> result=0.
  - SLL with R[rs2]=33 -> shift by 1.
- Handshake: hold in_valid high back-to-back with 3 commands -> in_ready low while busy, each accepted exactly once, out_valid pulses in order.
